// File: rtl/ast_video_pkg.sv
// Shared types and word layout for the background layer compositor.
package ast_video_pkg;

  // Mixing modes selected by the core
  typedef enum logic [1:0] {
    BG_OFF   = 2'd0,
    BG_KEY   = 2'd1,
    BG_BLEND = 2'd2,
    BG_ONLY  = 2'd3
  } bg_mode_e;

  // SDRAM fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } bg_fetch_state_e;

  // Channel slot positions inside a memory word {B,A,R,G}, in units of COLOR_W bits
  localparam int WORD_G_SLOT = 0;
  localparam int WORD_R_SLOT = 1;
  localparam int WORD_A_SLOT = 2;
  localparam int WORD_B_SLOT = 3;

endpackage

// File: rtl/bg_prefetch_fifo.sv
// Synchronous show-ahead FIFO holding prefetched background words.
module bg_prefetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A push into a full FIFO is only legal when a pop frees a slot in the same cycle
  assign push_ok = push_i & (~full_o | pop_i) & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  // Pointer and occupancy update; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage, not reset
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bg_layer_compositor.sv
// Streams a background image from SDRAM through a prefetch FIFO and mixes it
// with the core's foreground video, one word per active pixel.
module bg_layer_compositor
  import ast_video_pkg::*;
#(
  parameter int                COLOR_W    = 4,
  parameter int                ADDR_W     = 25,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                   clk_sys,
  input  logic                   RESET_L,
  input  logic                   ce_pix,
  input  logic                   hblank,
  input  logic                   vblank,
  input  logic                   vs,
  input  logic                   bg_valid,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   fg_rgb,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [4*COLOR_W-1:0]   mem_data,
  output logic [3*COLOR_W-1:0]   rgb_out,
  output logic                   underrun
);

  localparam int WORD_W = 4 * COLOR_W;
  localparam int RGB_W  = 3 * COLOR_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  // Word size in bytes, rounded up to whole 16-bit SDRAM words
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(2 * ((COLOR_W + 3) / 4));
  localparam logic [COLOR_W:0]  FULL_SCALE = {1'b1, {COLOR_W{1'b0}}};

  bg_fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic              vs_q;
  logic              underrun_q, underrun_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;

  logic              vs_rise, flush, active, pix_pop, ack_in_wait, push, pop;
  logic [WORD_W-1:0] fifo_rdata, bg_word;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;

  // Weighted mix of one channel; alpha max maps to full weight so both ends are exact
  function automatic logic [COLOR_W-1:0] blend_chan(input logic [COLOR_W-1:0] fg_c,
                                                    input logic [COLOR_W-1:0] bg_c,
                                                    input logic [COLOR_W-1:0] a);
    logic [COLOR_W:0]   wt, inv;
    logic [2*COLOR_W:0] acc;
    wt  = {1'b0, a} + {{COLOR_W{1'b0}}, a[COLOR_W-1]};
    inv = FULL_SCALE - wt;
    acc = {{(COLOR_W+1){1'b0}}, fg_c} * {{COLOR_W{1'b0}}, inv}
        + {{(COLOR_W+1){1'b0}}, bg_c} * {{COLOR_W{1'b0}}, wt};
    return COLOR_W'(acc >> COLOR_W);
  endfunction

  function automatic logic [RGB_W-1:0] composite(input bg_mode_e m, input logic vld,
                                                 input logic [RGB_W-1:0] fg,
                                                 input logic [WORD_W-1:0] w);
    logic [RGB_W-1:0]   bg, res;
    logic [COLOR_W-1:0] a;
    bg  = {w[WORD_R_SLOT*COLOR_W +: COLOR_W], w[WORD_G_SLOT*COLOR_W +: COLOR_W],
           w[WORD_B_SLOT*COLOR_W +: COLOR_W]};
    a   = w[WORD_A_SLOT*COLOR_W +: COLOR_W];
    res = fg;
    if (vld) begin
      case (m)
        BG_KEY:   res = ((|fg) && (a == '0)) ? fg : bg;
        BG_BLEND: for (int i = 0; i < 3; i++)
                    res[i*COLOR_W +: COLOR_W] = blend_chan(fg[i*COLOR_W +: COLOR_W],
                                                           bg[i*COLOR_W +: COLOR_W], a);
        BG_ONLY:  res = bg;
        default:  res = fg;
      endcase
    end
    return res;
  endfunction

  assign vs_rise     = vs & ~vs_q;
  assign flush       = vs_rise | ~bg_valid;
  assign active      = ~hblank & ~vblank;
  assign pix_pop     = ce_pix & active;
  assign ack_in_wait = (state_q == WAIT) & mem_ack;
  assign push        = ack_in_wait & ~drop_q & ~flush & ~fifo_full;
  assign pop         = pix_pop & ~fifo_empty & ~flush;
  assign bg_word     = fifo_empty ? '0 : fifo_rdata;

  bg_prefetch_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_n_i (RESET_L),
    .push_i  (push),
    .wdata_i (mem_data),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Fetch FSM state register
  always_ff @(posedge clk_sys) begin
    if (!RESET_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Fetch FSM next state: one request in flight, only while there is room for its word
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bg_valid && !flush && (fifo_count < DEPTH_CNT)) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM outputs
  always_comb begin
    mem_req = (state_q == REQ);
  end

  // Address, drop flag and underrun tracking; an in-flight word is discarded after a flush
  always_comb begin
    addr_d     = addr_q;
    drop_d     = drop_q;
    underrun_d = underrun_q;
    if (ack_in_wait) drop_d = 1'b0;
    if (push)        addr_d = addr_q + STEP;
    if (flush) begin
      addr_d = BASE_ADDR;
      if ((state_q != IDLE) && !ack_in_wait) drop_d = 1'b1;
    end
    if (pix_pop && fifo_empty && bg_valid) underrun_d = 1'b1;
    if (vs_rise) underrun_d = 1'b0;
  end

  // Control registers
  always_ff @(posedge clk_sys) begin
    if (!RESET_L) begin
      addr_q     <= BASE_ADDR;
      drop_q     <= 1'b0;
      vs_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      vs_q       <= vs;
      underrun_q <= underrun_d;
    end
  end

  // Output pixel: composite during active video, pass foreground through blanking
  always_comb begin
    rgb_d = rgb_q;
    if (ce_pix) rgb_d = active ? composite(bg_mode_e'(mode), bg_valid, fg_rgb, bg_word) : fg_rgb;
  end

  // Output pixel register
  always_ff @(posedge clk_sys) begin
    if (!RESET_L) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign mem_addr = addr_q;
  assign rgb_out  = rgb_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_bg_layer_compositor.sv
// Directed bench for bg_layer_compositor with a latency-programmable SDRAM responder.
module tb_bg_layer_compositor;

  logic        clk_sys = 1'b0;
  logic        RESET_L;
  logic        ce_pix, hblank, vblank, vs, bg_valid;
  logic [1:0]  mode;
  logic [11:0] fg_rgb;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [11:0] rgb_out;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  // Responder configuration and request log
  int          lat = 2;
  logic        resp_pulse = 1'b0;
  logic [15:0] resp_word = 16'h0000;
  int          req_count = 0;
  logic [24:0] addr_log [256];

  bg_layer_compositor #(.COLOR_W(4), .ADDR_W(25), .FIFO_DEPTH(8), .BASE_ADDR(25'd0)) dut (
    .clk_sys  (clk_sys),
    .RESET_L  (RESET_L),
    .ce_pix   (ce_pix),
    .hblank   (hblank),
    .vblank   (vblank),
    .vs       (vs),
    .bg_valid (bg_valid),
    .mode     (mode),
    .fg_rgb   (fg_rgb),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .rgb_out  (rgb_out),
    .underrun (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acknowledges each strobe lat cycles later with the word latched at request time
  initial begin
    int          cnt;
    logic        pending;
    logic        toggle;
    logic [15:0] pend_word;
    cnt = 0; pending = 1'b0; toggle = 1'b0; pend_word = '0;
    mem_ack = 1'b0; mem_data = '0;
    forever begin
      @(posedge clk_sys); #1;
      mem_ack = 1'b0;
      if (resp_pulse) begin
        pending  = 1'b0;
        mem_ack  = toggle;
        toggle   = ~toggle;
        mem_data = 16'hFFFF;
      end else begin
        if (pending) begin
          if (cnt <= 1) begin
            mem_ack  = 1'b1;
            mem_data = pend_word;
            pending  = 1'b0;
          end else cnt--;
        end
        if (mem_req) begin
          if (req_count < 256) addr_log[req_count] = mem_addr;
          req_count++;
          pending   = 1'b1;
          cnt       = lat;
          pend_word = resp_word;
        end
      end
    end
  end

  task automatic pixel(input logic [1:0] m, input logic [11:0] fg);
    @(negedge clk_sys);
    mode = m; fg_rgb = fg; ce_pix = 1'b1; hblank = 1'b0; vblank = 1'b0;
    @(negedge clk_sys);
    ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1;
  endtask

  task automatic frame_reload(input logic [15:0] word);
    lat = 2;
    resp_word = word;
    @(negedge clk_sys); vs = 1'b1;
    @(negedge clk_sys); vs = 1'b0;
    repeat (70) @(negedge clk_sys);
  endtask

  task automatic test_reset;
    RESET_L = 1'b0; bg_valid = 1'b1; resp_pulse = 1'b1;
    ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1; vs = 1'b0;
    mode = 2'd3; fg_rgb = 12'hABC; resp_word = 16'h080F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL reset_mem_req cycle %0d got=%b exp=0", i, mem_req);
      end
    end
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", rgb_out); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++;
    if (mem_addr !== 25'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    RESET_L = 1'b1; resp_pulse = 1'b0;
  endtask

  task automatic test_fill;
    int          base;
    logic [24:0] exp_a;
    base = req_count;
    repeat (50) @(negedge clk_sys);
    checks++;
    if (req_count - base !== 8) begin
      errors++; $display("FAIL fill_req_count got=%0d exp=8", req_count - base);
    end
    for (int i = 0; i < 8; i++) begin
      exp_a = 25'(2 * i);
      checks++;
      if (addr_log[base + i] !== exp_a) begin
        errors++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, addr_log[base + i], exp_a);
      end
    end
    repeat (20) @(negedge clk_sys);
    checks++;
    if (req_count - base !== 8 || mem_req !== 1'b0) begin
      errors++; $display("FAIL fill_stops got=%0d reqs exp=8", req_count - base);
    end
    checks++;
    if (mem_addr !== 25'd16) begin errors++; $display("FAIL fill_next_addr got=%0d exp=16", mem_addr); end
  endtask

  task automatic test_blend;
    pixel(2'd2, 12'hF00);
    checks++;
    if (rgb_out !== 12'h680) begin errors++; $display("FAIL blend_a8_F00 got=%h exp=680", rgb_out); end
    pixel(2'd2, 12'h0F0);
    checks++;
    if (rgb_out !== 12'h0F0) begin errors++; $display("FAIL blend_a8_0F0 got=%h exp=0F0", rgb_out); end
    pixel(2'd3, 12'hF0F);
    checks++;
    if (rgb_out !== 12'h0F0) begin errors++; $display("FAIL bg_only got=%h exp=0F0", rgb_out); end
    pixel(2'd0, 12'h123);
    checks++;
    if (rgb_out !== 12'h123) begin errors++; $display("FAIL fg_only got=%h exp=123", rgb_out); end
    frame_reload(16'h50A3);
    pixel(2'd2, 12'hF0F);
    checks++;
    if (rgb_out !== 12'hF0F) begin errors++; $display("FAIL blend_a0 got=%h exp=F0F", rgb_out); end
    frame_reload(16'hCF17);
    pixel(2'd2, 12'h8F2);
    checks++;
    if (rgb_out !== 12'h17C) begin errors++; $display("FAIL blend_amax got=%h exp=17C", rgb_out); end
  endtask

  task automatic test_key;
    frame_reload(16'h50A3);
    pixel(2'd1, 12'h000);
    checks++;
    if (rgb_out !== 12'hA35) begin errors++; $display("FAIL key_fg_black got=%h exp=A35", rgb_out); end
    pixel(2'd1, 12'h0F0);
    checks++;
    if (rgb_out !== 12'h0F0) begin errors++; $display("FAIL key_a0 got=%h exp=0F0", rgb_out); end
    frame_reload(16'h2345);
    pixel(2'd1, 12'h0F0);
    checks++;
    if (rgb_out !== 12'h452) begin errors++; $display("FAIL key_a3 got=%h exp=452", rgb_out); end
  endtask

  task automatic test_blanking;
    @(negedge clk_sys);
    mode = 2'd3; fg_rgb = 12'hABC; ce_pix = 1'b1; hblank = 1'b1; vblank = 1'b0;
    @(negedge clk_sys);
    ce_pix = 1'b0; vblank = 1'b1;
    checks++;
    if (rgb_out !== 12'hABC) begin errors++; $display("FAIL blank_passthru got=%h exp=ABC", rgb_out); end
    bg_valid = 1'b0;
    pixel(2'd3, 12'h5A5);
    checks++;
    if (rgb_out !== 12'h5A5) begin errors++; $display("FAIL no_bg_valid got=%h exp=5A5", rgb_out); end
  endtask

  task automatic test_underrun;
    lat = 20;
    @(negedge clk_sys); vs = 1'b1; bg_valid = 1'b1;
    @(negedge clk_sys); vs = 1'b0;
    pixel(2'd3, 12'hFFF);
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("FAIL underrun_zero_bg got=%h exp=000", rgb_out); end
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got=%b exp=1", underrun); end
    for (int i = 0; i < 14; i++) pixel(2'd3, 12'hFFF);
    checks++;
    if (mem_addr !== 25'd2) begin errors++; $display("FAIL underrun_addr got=%0d exp=2", mem_addr); end
    @(negedge clk_sys); vs = 1'b1;
    @(negedge clk_sys); vs = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
    checks++;
    if (mem_addr !== 25'd0) begin errors++; $display("FAIL frame_addr got=%0d exp=0", mem_addr); end
  endtask

  task automatic test_flush_wait;
    int base;
    int n;
    frame_reload(16'h1111);
    lat = 10;
    base = req_count;
    pixel(2'd0, 12'h000);
    n = 0;
    while (req_count < base + 1 && n < 20) begin @(negedge clk_sys); n++; end
    checks++;
    if (req_count < base + 1 || addr_log[base] !== 25'd16) begin
      errors++; $display("FAIL refill_req got=%0d reqs addr=%0d exp=1 addr=16", req_count - base, addr_log[base]);
    end
    repeat (3) @(negedge clk_sys);
    vs = 1'b1;
    @(negedge clk_sys); vs = 1'b0;
    resp_word = 16'h9F6E; lat = 2;
    n = 0;
    while (req_count < base + 2 && n < 40) begin @(negedge clk_sys); n++; end
    checks++;
    if (req_count < base + 2 || addr_log[base + 1] !== 25'd0) begin
      errors++; $display("FAIL flush_next_addr got=%0d reqs addr=%0d exp=2 addr=0", req_count - base, addr_log[base + 1]);
    end
    repeat (10) @(negedge clk_sys);
    pixel(2'd3, 12'h000);
    checks++;
    if (rgb_out !== 12'h6E9) begin errors++; $display("FAIL flush_dropped_word got=%h exp=6E9", rgb_out); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL flush_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_back_to_back;
    repeat (20) @(negedge clk_sys);
    @(negedge clk_sys);
    mode = 2'd0; fg_rgb = 12'h123; ce_pix = 1'b1; hblank = 1'b0; vblank = 1'b0;
    @(negedge clk_sys);
    mode = 2'd3;
    checks++;
    if (rgb_out !== 12'h123) begin errors++; $display("FAIL b2b_first got=%h exp=123", rgb_out); end
    @(negedge clk_sys);
    ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1;
    checks++;
    if (rgb_out !== 12'h6E9) begin errors++; $display("FAIL b2b_mode_switch got=%h exp=6E9", rgb_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_blend();
    test_key();
    test_blanking();
    test_underrun();
    test_flush_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
